// File: rtl/exe_pkg.sv
// Shared encodings, widths and the held-instruction payload for the execute stage.
package exe_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned DEST_W   = 6;
  localparam int unsigned ALU_OP_W = 4;
  localparam int unsigned MD_OP_W  = 3;
  localparam int unsigned HILO_BIT = 5;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_LUI  = 4'd11
  } alu_op_e;

  typedef enum logic [MD_OP_W-1:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4
  } md_op_e;

  // Raw op codes are held as plain vectors so undefined ALU codes survive intact.
  typedef struct packed {
    logic [XLEN-1:0]     pc;
    logic [ALU_OP_W-1:0] alu_op;
    logic [MD_OP_W-1:0]  md_op;
    logic [XLEN-1:0]     src1;
    logic [XLEN-1:0]     src2;
    logic [XLEN-1:0]     store_data;
    logic                reg_en;
    logic [DEST_W-1:0]   dest;
    logic                mem_read;
    logic                mem_write;
  } exe_fields_t;

  function automatic logic is_div_op(input logic [MD_OP_W-1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/exe_stage_div_iter.sv
// Iterative restoring radix-2 divider on operand magnitudes, one quotient bit per step.
module div_iter
  import exe_pkg::*;
#(
  parameter int unsigned STEPS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            signed_op,
  input  logic            run,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            done
);

  localparam int unsigned CNT_W = $clog2(STEPS + 1);

  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  quot;
  logic [XLEN-1:0]  rem;
  logic [XLEN-1:0]  dvsr;
  logic             neg_q;
  logic             neg_r;
  logic             by_zero;

  logic [XLEN:0]    rem_shift;
  logic [XLEN:0]    diff;
  logic             fits;
  logic [XLEN-1:0]  dividend_mag;
  logic [XLEN-1:0]  divisor_mag;

  assign dividend_mag = (signed_op && dividend[XLEN-1]) ? XLEN'(-dividend) : dividend;
  assign divisor_mag  = (signed_op && divisor[XLEN-1])  ? XLEN'(-divisor)  : divisor;

  // Shift the next dividend bit into the partial remainder and trial-subtract.
  assign rem_shift = {rem, quot[XLEN-1]};
  assign diff      = rem_shift - {1'b0, dvsr};
  assign fits      = ~diff[XLEN];
  assign done      = (cnt == CNT_W'(STEPS));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      quot    <= '0;
      rem     <= '0;
      dvsr    <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      by_zero <= 1'b0;
    end else if (start) begin
      cnt     <= '0;
      quot    <= dividend_mag;
      rem     <= '0;
      dvsr    <= divisor_mag;
      neg_q   <= signed_op && (dividend[XLEN-1] ^ divisor[XLEN-1]);
      neg_r   <= signed_op && dividend[XLEN-1];
      by_zero <= (divisor == '0);
    end else if (run && !done) begin
      cnt  <= cnt + CNT_W'(1);
      quot <= {quot[XLEN-2:0], fits};
      rem  <= fits ? diff[XLEN-1:0] : rem_shift[XLEN-1:0];
    end
  end

  // A zero divisor leaves the dividend magnitude in rem, so only the quotient needs forcing.
  assign quotient  = by_zero ? '1 : (neg_q ? XLEN'(-quot) : quot);
  assign remainder = neg_r ? XLEN'(-rem) : rem;

endmodule

// File: rtl/exe_stage.sv
// MIPS execute stage: holds one instruction, computes ALU / mult / iterative div results.
module exe_stage
  import exe_pkg::*;
#(
  parameter int unsigned DIV_STEPS = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                de_to_exe_valid,
  output logic                exe_allowin,
  input  logic [XLEN-1:0]     de_pc,
  input  logic [ALU_OP_W-1:0] de_alu_op,
  input  logic [MD_OP_W-1:0]  de_md_op,
  input  logic [XLEN-1:0]     de_src1,
  input  logic [XLEN-1:0]     de_src2,
  input  logic [XLEN-1:0]     de_store_data,
  input  logic                de_reg_en,
  input  logic [DEST_W-1:0]   de_dest,
  input  logic                de_mem_read,
  input  logic                de_mem_write,
  input  logic                mem_allowin,
  output logic                exe_to_mem_valid,
  output logic [XLEN-1:0]     exe_pc,
  output logic [XLEN-1:0]     exe_alu_result,
  output logic [XLEN-1:0]     exe_store_data,
  output logic                exe_mem_write,
  output logic [XLEN-1:0]     exe_hi,
  output logic [XLEN-1:0]     exe_lo,
  output logic                exe_reg_en,
  output logic [DEST_W-1:0]   exe_reg_waddr,
  output logic [XLEN-1:0]     exe_reg_wdata,
  output logic                exe_mem_read,
  output logic                exe_double_en
);

  logic            exe_valid;
  exe_fields_t     held;
  logic            held_is_div;
  logic            ready_go;
  logic            accept;
  logic [XLEN-1:0] alu_result;
  logic [4:0]      shamt;
  logic [63:0]     prod_s;
  logic [63:0]     prod_u;
  logic [XLEN-1:0] div_q;
  logic [XLEN-1:0] div_r;
  logic            div_done;

  assign held_is_div      = is_div_op(held.md_op);
  assign ready_go         = !held_is_div || div_done;
  assign exe_allowin      = !exe_valid || (ready_go && mem_allowin);
  assign accept           = exe_allowin && de_to_exe_valid;
  assign exe_to_mem_valid = exe_valid && ready_go;

  // Pipeline register: a downstream stall freezes everything held here.
  always_ff @(posedge clk) begin
    if (rst) begin
      exe_valid <= 1'b0;
      held      <= '0;
    end else if (exe_allowin) begin
      exe_valid <= de_to_exe_valid;
      if (de_to_exe_valid) begin
        held <= '{pc:         de_pc,
                  alu_op:     de_alu_op,
                  md_op:      de_md_op,
                  src1:       de_src1,
                  src2:       de_src2,
                  store_data: de_store_data,
                  reg_en:     de_reg_en,
                  dest:       de_dest,
                  mem_read:   de_mem_read,
                  mem_write:  de_mem_write};
      end
    end
  end

  assign shamt = held.src1[4:0];

  always_comb begin
    alu_result = '0;
    case (held.alu_op)
      ALU_ADD:  alu_result = held.src1 + held.src2;
      ALU_SUB:  alu_result = held.src1 - held.src2;
      ALU_AND:  alu_result = held.src1 & held.src2;
      ALU_OR:   alu_result = held.src1 | held.src2;
      ALU_XOR:  alu_result = held.src1 ^ held.src2;
      ALU_NOR:  alu_result = ~(held.src1 | held.src2);
      ALU_SLT:  alu_result = {31'b0, $signed(held.src1) < $signed(held.src2)};
      ALU_SLTU: alu_result = {31'b0, held.src1 < held.src2};
      ALU_SLL:  alu_result = held.src2 << shamt;
      ALU_SRL:  alu_result = held.src2 >> shamt;
      ALU_SRA:  alu_result = XLEN'($signed(held.src2) >>> shamt);
      ALU_LUI:  alu_result = {held.src2[15:0], 16'b0};
      default:  alu_result = '0;
    endcase
  end

  assign prod_s = 64'($signed({{32{held.src1[XLEN-1]}}, held.src1}) *
                      $signed({{32{held.src2[XLEN-1]}}, held.src2}));
  assign prod_u = {32'b0, held.src1} * {32'b0, held.src2};

  // Operands come straight from decode so the divider is primed on the latching edge.
  div_iter #(
    .STEPS(DIV_STEPS)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (accept),
    .signed_op (de_md_op == MD_DIV),
    .run       (exe_valid && held_is_div),
    .dividend  (de_src1),
    .divisor   (de_src2),
    .quotient  (div_q),
    .remainder (div_r),
    .done      (div_done)
  );

  // HI/LO only expose a divide result once it is complete.
  always_comb begin
    exe_hi = '0;
    exe_lo = '0;
    case (held.md_op)
      MD_MULT:  {exe_hi, exe_lo} = prod_s;
      MD_MULTU: {exe_hi, exe_lo} = prod_u;
      MD_DIV, MD_DIVU: begin
        if (div_done) begin
          exe_hi = div_r;
          exe_lo = div_q;
        end
      end
      default: ;
    endcase
  end

  assign exe_pc         = held.pc;
  assign exe_alu_result = alu_result;
  assign exe_store_data = held.store_data;
  assign exe_mem_write  = exe_valid && held.mem_write;
  assign exe_mem_read   = exe_valid && held.mem_read;
  assign exe_reg_en     = exe_valid && held.reg_en;
  assign exe_reg_waddr  = held.dest;
  assign exe_reg_wdata  = alu_result;
  assign exe_double_en  = exe_valid && (held.md_op != MD_NONE);

endmodule
